id_ex_skid: RTL and testbench

ID_EX_SKID -- requirements
Module: id_ex_skid

---
 rtl/id_ex_skid.sv | 141 ++++++++++++++
 tb/tb_id_ex_skid.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_skid.sv
// ID->EX pipeline register with a one-deep skid buffer.
// Registered id_ready; bubbles dropped; branch redirect registered.
module id_ex_skid #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int OP_W  = 7,
  parameter int SUB_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [OP_W-1:0]  id_t,
  input  logic [SUB_W-1:0] id_st,
  input  logic             id_sst,
  input  logic [XLEN-1:0]  id_n1,
  input  logic [XLEN-1:0]  id_n2,
  input  logic [RA_W-1:0]  id_wa,
  input  logic             id_we,
  input  logic [XLEN-1:0]  id_nn,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_off,
  input  logic             id_pce,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [OP_W-1:0]  ex_t,
  output logic [SUB_W-1:0] ex_st,
  output logic             ex_sst,
  output logic [XLEN-1:0]  ex_n1,
  output logic [XLEN-1:0]  ex_n2,
  output logic [RA_W-1:0]  ex_wa,
  output logic             ex_we,
  output logic [XLEN-1:0]  ex_nn,
  output logic [XLEN-1:0]  br_pc,
  output logic             br_pce,
  output logic [1:0]       occ
);

  typedef struct packed {
    logic [OP_W-1:0]  t;
    logic [SUB_W-1:0] st;
    logic             sst;
    logic [XLEN-1:0]  n1;
    logic [XLEN-1:0]  n2;
    logic [RA_W-1:0]  wa;
    logic             we;
    logic [XLEN-1:0]  nn;
  } pl_t;

  pl_t             in_pl;
  pl_t             out_q, out_d;
  pl_t             skid_q, skid_d;
  logic            out_v_q, out_v_d;
  logic            skid_v_q, skid_v_d;
  logic [XLEN-1:0] br_pc_q, br_pc_d;
  logic            br_pce_q, br_pce_d;
  logic [XLEN-1:0] br_tgt;
  logic            acc, beat, retire, out_free;

  assign in_pl = '{t: id_t, st: id_st, sst: id_sst,
                   n1: id_n1, n2: id_n2, wa: id_wa,
                   we: id_we, nn: id_nn};

  assign id_ready = ~skid_v_q;
  assign acc      = id_valid & id_ready;
  assign beat     = acc & (id_t != '0);
  assign retire   = out_v_q & ex_ready;
  assign out_free = ~out_v_q | retire;

  // Next state: retire, refill OUT from SKID, then place the new beat.
  always_comb begin
    out_d    = out_q;
    skid_d   = skid_q;
    out_v_d  = out_v_q & ~retire;
    skid_v_d = skid_v_q;
    if (skid_v_q && out_free) begin
      out_d    = skid_q;
      out_v_d  = 1'b1;
      skid_v_d = 1'b0;
    end
    if (beat) begin
      if (out_free) begin
        out_d   = in_pl;
        out_v_d = 1'b1;
      end else begin
        skid_d   = in_pl;
        skid_v_d = 1'b1;
      end
    end
    if (flush) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end
  end

  // Branch redirect: target with bit 0 cleared, one-cycle strobe.
  always_comb begin
    br_tgt    = id_pc + id_off;
    br_tgt[0] = 1'b0;
    br_pc_d   = br_pc_q;
    br_pce_d  = 1'b0;
    if (acc && id_pce && !flush) begin
      br_pc_d  = br_tgt;
      br_pce_d = 1'b1;
    end
  end

  // State registers; async reset clears everything visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      skid_q   <= '0;
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
      br_pc_q  <= '0;
      br_pce_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      skid_q   <= skid_d;
      out_v_q  <= out_v_d;
      skid_v_q <= skid_v_d;
      br_pc_q  <= br_pc_d;
      br_pce_q <= br_pce_d;
    end
  end

  assign ex_valid = out_v_q;
  assign ex_t     = out_q.t;
  assign ex_st    = out_q.st;
  assign ex_sst   = out_q.sst;
  assign ex_n1    = out_q.n1;
  assign ex_n2    = out_q.n2;
  assign ex_wa    = out_q.wa;
  assign ex_we    = out_q.we;
  assign ex_nn    = out_q.nn;
  assign br_pc    = br_pc_q;
  assign br_pce   = br_pce_q;
  assign occ      = {out_v_q & skid_v_q, out_v_q ^ skid_v_q};

endmodule

// File: tb/tb_id_ex_skid.sv
// Directed + random bench for id_ex_skid.
// Scoreboard queue mirrors the beats held inside the DUT.
module tb_id_ex_skid;

  logic        clk = 1'b0;
  logic        rst_n, flush, id_valid, id_ready;
  logic [6:0]  id_t;
  logic [2:0]  id_st;
  logic        id_sst, id_we, id_pce;
  logic [31:0] id_n1, id_n2, id_nn, id_pc, id_off;
  logic [4:0]  id_wa;
  logic        ex_valid, ex_ready;
  logic [6:0]  ex_t;
  logic [2:0]  ex_st;
  logic        ex_sst, ex_we, br_pce;
  logic [31:0] ex_n1, ex_n2, ex_nn, br_pc;
  logic [4:0]  ex_wa;
  logic [1:0]  occ;

  int vectors = 0;
  int miscompares = 0;
  logic [112:0] q[$];
  logic [31:0]  exp_brpc;
  logic         exp_pce;

  id_ex_skid dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_t(id_t), .id_st(id_st), .id_sst(id_sst),
    .id_n1(id_n1), .id_n2(id_n2), .id_wa(id_wa),
    .id_we(id_we), .id_nn(id_nn),
    .id_pc(id_pc), .id_off(id_off), .id_pce(id_pce),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_t(ex_t), .ex_st(ex_st), .ex_sst(ex_sst),
    .ex_n1(ex_n1), .ex_n2(ex_n2), .ex_wa(ex_wa),
    .ex_we(ex_we), .ex_nn(ex_nn),
    .br_pc(br_pc), .br_pce(br_pce), .occ(occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [112:0] in_pl();
    return {id_t, id_st, id_sst, id_n1, id_n2,
            id_wa, id_we, id_nn};
  endfunction

  function automatic logic [112:0] ex_pl();
    return {ex_t, ex_st, ex_sst, ex_n1, ex_n2,
            ex_wa, ex_we, ex_nn};
  endfunction

  task automatic beat(input logic v, input logic [6:0] t,
                      input logic [31:0] n1,
                      input logic [31:0] n2);
    id_valid = v;
    id_t     = t;
    id_n1    = n1;
    id_n2    = n2;
    id_st    = 3'($urandom);
    id_sst   = 1'($urandom);
    id_wa    = 5'($urandom);
    id_we    = 1'($urandom);
    id_nn    = $urandom;
  endtask

  // Check pre-edge state, update model, clock, check redirect.
  task automatic tick();
    logic acc;
    chk("id_ready", 128'(id_ready), 128'(q.size() < 2));
    chk("occ", 128'(occ), 128'(q.size()));
    chk("ex_valid", 128'(ex_valid), 128'(q.size() != 0));
    if (q.size() != 0)
      chk("ex_payload", 128'(ex_pl()), 128'(q[0]));
    acc = id_valid && (q.size() < 2);
    if (flush) begin
      q.delete();
      exp_pce = 1'b0;
    end else begin
      if (q.size() != 0 && ex_ready)
        void'(q.pop_front());
      if (acc && id_t != 7'd0)
        q.push_back(in_pl());
      exp_pce = acc && id_pce;
      if (acc && id_pce)
        exp_brpc = (id_pc + id_off) & 32'hFFFF_FFFE;
    end
    @(posedge clk);
    #1;
    chk("br_pce", 128'(br_pce), 128'(exp_pce));
    chk("br_pc", 128'(br_pc), 128'(exp_brpc));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    id_pce = 1'b0; id_pc = '0; id_off = '0;
    beat(1'b0, 7'd0, 32'd0, 32'd0);
    exp_brpc = '0;
    exp_pce = 1'b0;
    #12;
    chk("rst_ex_valid", 128'(ex_valid), 128'd0);
    chk("rst_id_ready", 128'(id_ready), 128'd1);
    chk("rst_occ", 128'(occ), 128'd0);
    chk("rst_br_pc", 128'(br_pc), 128'd0);
    chk("rst_ex_t", 128'(ex_t), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Single beat, one-cycle latency.
    beat(1'b1, 7'h33, 32'd5, 32'd7);
    tick();
    beat(1'b0, 7'd0, 32'd0, 32'd0);
    chk("lat_ex_t", 128'(ex_t), 128'h33);
    chk("lat_ex_n1", 128'(ex_n1), 128'd5);
    chk("lat_ex_n2", 128'(ex_n2), 128'd7);
    tick();
    tick();

    // Backpressure: A in OUT, B in SKID, C held.
    ex_ready = 1'b0;
    beat(1'b1, 7'h13, 32'hA, 32'h1); tick();
    beat(1'b1, 7'h23, 32'hB, 32'h2); tick();
    beat(1'b1, 7'h63, 32'hC, 32'h3); tick();
    tick();
    chk("bp_occ2", 128'(occ), 128'd2);
    chk("bp_ready0", 128'(id_ready), 128'd0);
    ex_ready = 1'b1;
    tick();
    tick();
    beat(1'b0, 7'd0, 32'd0, 32'd0);
    tick(); tick(); tick();
    chk("bp_drained", 128'(occ), 128'd0);

    // Bubble with branch request.
    beat(1'b1, 7'd0, 32'd0, 32'd0);
    id_pce = 1'b1; id_pc = 32'h100; id_off = 32'h15;
    tick();
    chk("bub_br_pc", 128'(br_pc), 128'h114);
    beat(1'b0, 7'd0, 32'd0, 32'd0);
    id_pce = 1'b0;
    tick();

    // Wrapping target.
    beat(1'b1, 7'h6F, 32'd1, 32'd2);
    id_pce = 1'b1; id_pc = 32'hFFFF_FFF0; id_off = 32'h20;
    tick();
    chk("wrap_br_pc", 128'(br_pc), 128'h10);
    beat(1'b0, 7'd0, 32'd0, 32'd0);
    id_pce = 1'b0;
    tick();

    // Flush while full, with a beat and branch offered.
    ex_ready = 1'b0;
    beat(1'b1, 7'h13, 32'd11, 32'd12); tick();
    beat(1'b1, 7'h13, 32'd13, 32'd14); tick();
    flush = 1'b1; id_pce = 1'b1;
    beat(1'b1, 7'h33, 32'd15, 32'd16);
    tick();
    flush = 1'b0; id_pce = 1'b0;
    beat(1'b0, 7'd0, 32'd0, 32'd0);
    chk("fl_occ", 128'(occ), 128'd0);
    tick();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      beat(1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) == 0) ? 7'd0 : 7'($urandom),
           $urandom, $urandom);
      ex_ready = 1'($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 40) == 0);
      id_pce   = ($urandom_range(0, 5) == 0);
      id_pc    = $urandom;
      id_off   = $urandom;
      tick();
    end
    flush = 1'b0; id_pce = 1'b0;

    // Async reset between edges while full.
    ex_ready = 1'b0;
    beat(1'b1, 7'h13, 32'd1, 32'd1); tick();
    beat(1'b1, 7'h13, 32'd2, 32'd2); tick();
    id_pce = 1'b1; id_pc = 32'h40; id_off = 32'h4;
    beat(1'b1, 7'h13, 32'd3, 32'd3); tick();
    id_pce = 1'b0;
    beat(1'b0, 7'd0, 32'd0, 32'd0);
    chk("pre_rst_occ", 128'(occ), 128'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ex_valid", 128'(ex_valid), 128'd0);
    chk("arst_occ", 128'(occ), 128'd0);
    chk("arst_br_pce", 128'(br_pce), 128'd0);
    chk("arst_br_pc", 128'(br_pc), 128'd0);
    chk("arst_id_ready", 128'(id_ready), 128'd1);
    q.delete();
    exp_brpc = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ex_ready = 1'b1;
    beat(1'b1, 7'h37, 32'd9, 32'd8);
    tick();
    beat(1'b0, 7'd0, 32'd0, 32'd0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
